// File: rtl/sensor_access_scheduler_pkg.sv
// Shared types and default sizing for the sensor access scheduler.
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/sensor_access_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after rr_ptr_i.
module rr_arbiter
    import sensor_pkg::*;
#(
    parameter int  NUM_CH = DEF_NUM_CH,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   rr_ptr_i,
    output logic              any_req_o,
    output logic [CH_W-1:0]   idx_o
);

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        int j;
        j         = 0;
        any_req_o = 1'b0;
        idx_o     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = (int'(rr_ptr_i) + k) % NUM_CH;
            if (req_i[j]) begin
                any_req_o = 1'b1;
                idx_o     = CH_W'(j);
            end
        end
    end

endmodule

// File: rtl/sensor_access_scheduler.sv
// Shares one data processor among NUM_CH sensor channels: pick round-robin,
// issue one sample, then wait for completion or a bounded timeout.
module sensor_access_scheduler
    import sensor_pkg::*;
#(
    parameter int  NUM_CH  = DEF_NUM_CH,
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  TIMEOUT = DEF_TIMEOUT,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        grant,
    output logic                     proc_valid,
    output logic [DATA_W-1:0]        proc_data,
    input  logic                     proc_done,
    input  logic [DATA_W-1:0]        proc_result,
    output logic                     result_valid,
    output logic [DATA_W-1:0]        result_data,
    output logic [CH_W-1:0]          result_ch,
    output logic                     timeout_err,
    output logic                     busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t      state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              proc_valid_q, proc_valid_d;
    logic [DATA_W-1:0] proc_data_q, proc_data_d;
    logic              result_valid_q, result_valid_d;
    logic [DATA_W-1:0] result_data_q, result_data_d;
    logic [CH_W-1:0]   result_ch_q, result_ch_d;
    logic              timeout_err_q, timeout_err_d;
    logic              busy_q, busy_d;

    logic              any_req;
    logic [CH_W-1:0]   pick;
    logic [DATA_W-1:0] ch_data [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
        assign ch_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .any_req_o (any_req),
        .idx_o     (pick)
    );

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        rr_ptr_d       = rr_ptr_q;
        wait_cnt_d     = wait_cnt_q;
        grant_d        = '0;
        proc_valid_d   = 1'b0;
        proc_data_d    = proc_data_q;
        result_valid_d = 1'b0;
        result_data_d  = result_data_q;
        result_ch_d    = result_ch_q;
        timeout_err_d  = 1'b0;
        busy_d         = busy_q;

        case (state_q)
            IDLE: begin
                // Issue strobes are loaded here so they are registered during ISSUE.
                if (any_req) begin
                    ch_d          = pick;
                    proc_data_d   = ch_data[pick];
                    grant_d[pick] = 1'b1;
                    proc_valid_d  = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                rr_ptr_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // Completion is checked first so it beats a same-cycle timeout.
                if (proc_done) begin
                    result_data_d  = proc_result;
                    result_ch_d    = ch_q;
                    result_valid_d = 1'b1;
                    busy_d         = 1'b0;
                    state_d        = IDLE;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_ch_d   = ch_q;
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            ch_q           <= '0;
            rr_ptr_q       <= '0;
            wait_cnt_q     <= '0;
            grant_q        <= '0;
            proc_valid_q   <= 1'b0;
            proc_data_q    <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_ch_q    <= '0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            rr_ptr_q       <= rr_ptr_d;
            wait_cnt_q     <= wait_cnt_d;
            grant_q        <= grant_d;
            proc_valid_q   <= proc_valid_d;
            proc_data_q    <= proc_data_d;
            result_valid_q <= result_valid_d;
            result_data_q  <= result_data_d;
            result_ch_q    <= result_ch_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
        end
    end

    assign grant        = grant_q;
    assign proc_valid   = proc_valid_q;
    assign proc_data    = proc_data_q;
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign result_ch    = result_ch_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = busy_q;

endmodule
